// File: rtl/pc_fetch_unit.sv
// PC register and two-state instruction fetch sequencer with redirect capture.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets trap to TRAP_VECTOR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_trap
);

  typedef enum logic {
    FETCH   = 1'b0,
    DELIVER = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] tgt;
  logic [31:0] next_pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        fetch_redir;
  logic [31:0] fetch_target;

  assign redirect   = jump | branch_taken;
  assign raw_target = jump ? jump_target : branch_target;

`ifdef PC_ALIGN_CHECK_EN
  logic tgt_trap;
  logic pend_trap;
  logic trap_q;

  assign tgt_trap = (raw_target[1:0] != 2'b00);
  assign tgt      = tgt_trap ? TRAP_VECTOR : raw_target;
  assign misalign_trap = trap_q;

  // Trap pulse fires on the cycle pc is loaded with TRAP_VECTOR
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q    <= 1'b0;
      pend_trap <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            if (fetch_redir) begin
              trap_q <= pend_valid ? pend_trap
                                   : tgt_trap;
            end
            pend_trap <= 1'b0;
          end else if (redirect && !pend_valid) begin
            pend_trap <= tgt_trap;
          end
        end
        DELIVER: begin
          if (!stall && redirect) begin
            trap_q <= tgt_trap;
          end
        end
      endcase
    end
  end
`else
  assign tgt = raw_target & 32'hFFFF_FFFC;
  assign misalign_trap = 1'b0;
`endif

  assign next_pc      = redirect ? tgt : pc_plus4;
  assign fetch_redir  = pend_valid | redirect;
  assign fetch_target = pend_valid ? pend_target : tgt;
  assign imem_addr    = pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: ack moves to DELIVER unless a redirect kills the word
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (imem_ack && !fetch_redir) begin
          state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        if (!stall) begin
          state_nxt = FETCH;
        end
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    imem_req = (state == FETCH);
  end

  // PC, instruction and pending-redirect datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            if (fetch_redir) begin
              pc         <= fetch_target;
              pend_valid <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
            end
          end else if (redirect && !pend_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= tgt;
          end
        end
        DELIVER: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch, stall,
// redirect, wrap, reset and misalign sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        prev_v = 1'b0;

  always #5 clk = ~clk;

  assign pc_plus4 = pc + 32'd4;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .misalign_trap (misalign_trap)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: each new delivery is matched against the scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (instr_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: pc %h instr %h",
                 pc, instr);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_pc", pc, e[63:32]);
        chk("deliver_instr", instr, e[31:0]);
      end
    end
    prev_v = instr_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request is acked one cycle after it is seen; ends in DELIVER
  task automatic fetch(input logic [31:0] pc_exp,
                       input logic [31:0] word);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, pc_exp);
    step();
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back({pc_exp, word});
    step();
    imem_ack = 1'b0;
    chk("req_drop", imem_req, 0);
    chk("trap_idle", misalign_trap, 0);
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_trap", misalign_trap, 0);
    chk("rst_req", imem_req, 1);
    reset = 1'b0;

    fetch(32'h0, 32'h1111_0000);
    step();
    fetch(32'h4, 32'h1111_0001);
    step();
    fetch(32'h8, 32'h1111_0002);

    stall       = 1'b1;
    jump        = 1'b1;
    jump_target = 32'h100;
    repeat (3) begin
      step();
      chk("stall_pc", pc, 32'h8);
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr, 32'h1111_0002);
    end
    stall = 1'b0;
    jump  = 1'b0;
    step();
    chk("release_pc", pc, 32'hC);
    fetch(32'hC, 32'h1111_0003);

    jump          = 1'b1;
    jump_target   = 32'h40;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    step();
    jump         = 1'b0;
    branch_taken = 1'b0;
    chk("prio_pc", pc, 32'h40);
    chk("prio_valid", instr_valid, 0);

    branch_taken  = 1'b1;
    branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    jump         = 1'b1;
    jump_target  = 32'h300;
    step();
    jump       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("pend_pc", pc, 32'h200);
    chk("pend_valid", instr_valid, 0);
    chk("pend_req", imem_req, 1);
    chk("pend_addr", imem_addr, 32'h200);

    fetch(32'h200, 32'h2222_0000);
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    chk("top_pc", pc, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h3333_0000);
    step();
    chk("wrap_pc", pc, 32'h0);

    fetch(32'h0, 32'h3333_0001);
    jump        = 1'b1;
    jump_target = 32'h10;
    step();
    jump = 1'b0;
    chk("pre_rst_pc", pc, 32'h10);
    step();
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    reset    = 1'b0;
    imem_ack = 1'b0;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_req", imem_req, 1);
    chk("mid_rst_instr", instr, 32'h0);

    imem_ack   = 1'b1;
    imem_rdata = 32'h4444_0000;
    exp_q.push_back({32'h0, 32'h4444_0000});
    step();
    imem_ack = 1'b0;
    chk("late_ack_valid", instr_valid, 1);

    jump        = 1'b1;
    jump_target = 32'h42;
    step();
    jump = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h8000_0180);
    chk("mis_trap", misalign_trap, 1);
    step();
    chk("mis_trap_end", misalign_trap, 0);
`else
    chk("mis_pc", pc, 32'h40);
    chk("mis_trap", misalign_trap, 0);
    step();
    chk("mis_trap_end", misalign_trap, 0);
`endif

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) step();
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
